// File: rtl/thresholding_axilite_writer_if.sv
// Bundle of the threshold AXI-Stream input and the AXI-Lite write channels
// between the threshold writer (master) and its stream source / target core (slave).
`timescale 1ns/1ps
interface thresholding_axilite_writer_if #(
   parameter int A_BITS = 4,
   parameter int D_BITS = 16
);
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [D_BITS-1:0] s_axis_tdata;

   logic              m_axilite_AWVALID;
   logic              m_axilite_AWREADY;
   logic [A_BITS-1:0] m_axilite_AWADDR;
   logic              m_axilite_WVALID;
   logic              m_axilite_WREADY;
   logic [31:0]       m_axilite_WDATA;
   logic [3:0]        m_axilite_WSTRB;
   logic              m_axilite_BVALID;
   logic              m_axilite_BREADY;
   logic [1:0]        m_axilite_BRESP;

   modport master (
      input  s_axis_tvalid, s_axis_tdata,
      input  m_axilite_AWREADY, m_axilite_WREADY, m_axilite_BVALID, m_axilite_BRESP,
      output s_axis_tready,
      output m_axilite_AWVALID, m_axilite_AWADDR, m_axilite_WVALID, m_axilite_WDATA,
      output m_axilite_WSTRB, m_axilite_BREADY
   );

   modport slave (
      output s_axis_tvalid, s_axis_tdata,
      output m_axilite_AWREADY, m_axilite_WREADY, m_axilite_BVALID, m_axilite_BRESP,
      input  s_axis_tready,
      input  m_axilite_AWVALID, m_axilite_AWADDR, m_axilite_WVALID, m_axilite_WDATA,
      input  m_axilite_WSTRB, m_axilite_BREADY
   );
endinterface

// File: rtl/thresholding_axilite_writer.sv
// Streams a full threshold table into a thresholding core, one AXI-Lite write per value.
// Optional: define THRESHOLDING_WRITER_BRESP_CHECK_EN to flag error responses and abort.
`timescale 1ns/1ps
module thresholding_axilite_writer #(
   parameter int N = 4,
   parameter int M = 16,
   parameter int C = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic err,
   thresholding_axilite_writer_if.master bus
);
   localparam int A_BITS = $clog2(C) + N;
   localparam int C_BITS = (C < 2) ? 1 : $clog2(C);
   localparam logic [N-1:0]      LAST_IDX = N'((1 << N) - 2);
   localparam logic [C_BITS-1:0] LAST_CH  = C_BITS'(C - 1);

`ifdef THRESHOLDING_WRITER_BRESP_CHECK_EN
   localparam bit BRESP_CHECK = 1'b1;
`else
   localparam bit BRESP_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RESP, DONE} state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      index_q;
   logic [C_BITS-1:0] chan_q;
   logic [M-1:0]      data_q;
   logic              aw_done_q, w_done_q, err_q;
   logic              aw_hs, w_hs, last_write, bresp_fail;

   assign aw_hs      = bus.m_axilite_AWVALID && bus.m_axilite_AWREADY;
   assign w_hs       = bus.m_axilite_WVALID && bus.m_axilite_WREADY;
   assign last_write = (index_q == LAST_IDX) && (chan_q == LAST_CH);
   assign bresp_fail = BRESP_CHECK && (bus.m_axilite_BRESP != 2'b00);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = FETCH;
         FETCH: if (bus.s_axis_tvalid) state_d = ISSUE;
         ISSUE: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = RESP;
         RESP:  if (bus.m_axilite_BVALID) state_d = (last_write || bresp_fail) ? DONE : FETCH;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are pure decodes of registered state, so no input reaches them combinationally.
   always_comb begin
      busy                  = (state_q != IDLE);
      done                  = (state_q == DONE);
      bus.s_axis_tready     = (state_q == FETCH);
      bus.m_axilite_AWVALID = (state_q == ISSUE) && !aw_done_q;
      bus.m_axilite_WVALID  = (state_q == ISSUE) && !w_done_q;
      bus.m_axilite_BREADY  = (state_q == RESP);
   end

   // NOTE: the datapath registers are reset too, because AWADDR and WDATA must read zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         index_q   <= '0;
         chan_q    <= '0;
         data_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (start) begin
               index_q <= '0;
               chan_q  <= '0;
               err_q   <= 1'b0;
            end
            FETCH: begin
               aw_done_q <= 1'b0;
               w_done_q  <= 1'b0;
               if (bus.s_axis_tvalid) data_q <= bus.s_axis_tdata[M-1:0];
            end
            ISSUE: begin
               if (aw_hs) aw_done_q <= 1'b1;
               if (w_hs)  w_done_q  <= 1'b1;
            end
            RESP: if (bus.m_axilite_BVALID) begin
               if (bresp_fail) err_q <= 1'b1;
               if (index_q == LAST_IDX) begin
                  index_q <= '0;
                  chan_q  <= (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
               end else begin
                  index_q <= index_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Index 2^N-1 is never reached, so the address is simply {channel, index}.
   if (C < 2) begin : g_addr_single
      assign bus.m_axilite_AWADDR = A_BITS'(index_q);
   end else begin : g_addr_multi
      assign bus.m_axilite_AWADDR = A_BITS'({chan_q, index_q});
   end

   assign bus.m_axilite_WDATA = 32'(data_q);
   assign bus.m_axilite_WSTRB = 4'hF;
   assign err                 = err_q;
endmodule

// File: tb/tb_thresholding_axilite_writer.sv
// Self-checking bench: table-driven and randomized load sequences against a
// behavioural slave/stream model, plus reset and single-channel sequences.
`timescale 1ns/1ps
module tb_thresholding_axilite_writer;
   localparam int NA = 2, MA = 12, CA = 2;
   localparam int ABITS_A  = $clog2(CA) + NA;
   localparam int DBITS_A  = ((MA + 7) / 8) * 8;
   localparam int PAD_A    = DBITS_A - MA;
   localparam int PER_CH_A = (1 << NA) - 1;
   localparam int WRITES_A = CA * PER_CH_A;
   localparam int NB = 3, MB = 8, CB = 1;
   localparam int ABITS_B  = $clog2(CB) + NB;
   localparam int DBITS_B  = ((MB + 7) / 8) * 8;
   localparam int WRITES_B = CB * ((1 << NB) - 1);

`ifdef THRESHOLDING_WRITER_BRESP_CHECK_EN
   localparam int ERR_WRITES = 3;
   localparam bit ERR_FLAG   = 1'b1;
`else
   localparam int ERR_WRITES = WRITES_A;
   localparam bit ERR_FLAG   = 1'b0;
`endif

   typedef struct {
      string name;
      int    aw_delay;
      int    w_delay;
      int    b_delay;
      int    gap_at;
      int    gap_len;
      int    err_at;
      bit    start_in_resp;
      bit    fixed;
      int    exp_writes;
      bit    exp_err;
   } vec_t;

   typedef struct {
      logic [ABITS_A-1:0] addr;
      logic [31:0]        data;
      logic [3:0]         strb;
      int                 aw_cyc;
      int                 w_cyc;
      int                 aw_t;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic start_a, busy_a, done_a, err_a;
   logic start_b, busy_b, done_b, err_b;

   always #5 clk = ~clk;

   thresholding_axilite_writer_if #(.A_BITS(ABITS_A), .D_BITS(DBITS_A)) bus_a ();
   thresholding_axilite_writer_if #(.A_BITS(ABITS_B), .D_BITS(DBITS_B)) bus_b ();

   thresholding_axilite_writer #(.N(NA), .M(MA), .C(CA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .err(err_a), .bus(bus_a)
   );
   thresholding_axilite_writer #(.N(NB), .M(MB), .C(CB)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b), .bus(bus_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Slave / stream model state for dut_a
   int  aw_delay, w_delay, b_delay, gap_at, gap_len, gap_left, err_at;
   bit  start_in_resp;
   logic [MA-1:0] strm_q[$];
   wr_t wlog[$];
   int  consumed, done_pulses, gcyc, done_cyc, last_b_cyc;
   bit  aw_got, w_got;
   int  aw_cyc, w_cyc, b_wait, aw_t;
   logic [ABITS_A-1:0] cur_addr;
   logic [31:0]        cur_data;
   logic [3:0]         cur_strb;
   vec_t tbl[11];

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic clear_slave();
      aw_got = 0; w_got = 0; aw_cyc = 0; w_cyc = 0; b_wait = 0;
   endtask

   // Decide inputs for the coming edge from the current outputs, log handshakes, advance one cycle.
   task automatic tick_a();
      bit  pending, tv;
      wr_t r;
      if (done_a) begin
         done_pulses++;
         done_cyc = gcyc;
         check("busy_during_done", busy_a, 1);
      end
      if (start_in_resp) start_a = bus_a.m_axilite_BREADY;
      pending = aw_got && w_got;
      if (bus_a.m_axilite_BREADY) check("bready_after_aw_and_w", pending, 1);

      tv = (strm_q.size() > 0) && !((consumed == gap_at) && (gap_left > 0));
      if (bus_a.s_axis_tready && (consumed == gap_at) && (gap_left > 0)) begin
         gap_left--;
         check("awvalid_low_in_stall", bus_a.m_axilite_AWVALID, 0);
      end
      bus_a.s_axis_tvalid = tv;
      bus_a.s_axis_tdata  = tv ? {PAD_A'($urandom), strm_q[0]} : DBITS_A'($urandom);
      if (tv && bus_a.s_axis_tready) begin
         void'(strm_q.pop_front());
         consumed++;
      end

      if (bus_a.m_axilite_AWVALID) begin
         check("awvalid_once_per_write", aw_got, 0);
         if (aw_cyc > 0) check("awaddr_stable", bus_a.m_axilite_AWADDR, cur_addr);
         cur_addr = bus_a.m_axilite_AWADDR;
         aw_cyc++;
         bus_a.m_axilite_AWREADY = (aw_cyc > aw_delay);
         if (aw_cyc > aw_delay) begin aw_got = 1; aw_t = gcyc; end
      end else begin
         bus_a.m_axilite_AWREADY = 1'b0;
      end

      if (bus_a.m_axilite_WVALID) begin
         check("wvalid_once_per_write", w_got, 0);
         if (w_cyc > 0) check("wdata_stable", bus_a.m_axilite_WDATA, cur_data);
         cur_data = bus_a.m_axilite_WDATA;
         cur_strb = bus_a.m_axilite_WSTRB;
         w_cyc++;
         bus_a.m_axilite_WREADY = (w_cyc > w_delay);
         if (w_cyc > w_delay) w_got = 1;
      end else begin
         bus_a.m_axilite_WREADY = 1'b0;
      end

      if (pending) begin
         bus_a.m_axilite_BVALID = (b_wait >= b_delay);
         b_wait++;
      end else begin
         bus_a.m_axilite_BVALID = 1'b0;
      end
      bus_a.m_axilite_BRESP = (wlog.size() == err_at) ? 2'b10 : 2'b00;
      if (bus_a.m_axilite_BVALID && bus_a.m_axilite_BREADY) begin
         r.addr = cur_addr; r.data = cur_data; r.strb = cur_strb;
         r.aw_cyc = aw_cyc; r.w_cyc = w_cyc; r.aw_t = aw_t;
         wlog.push_back(r);
         last_b_cyc = gcyc;
         clear_slave();
      end
      @(negedge clk);
      gcyc++;
   endtask

   task automatic run_seq(input vec_t v);
      logic [MA-1:0] vals[$];
      logic [MA-1:0] x;
      int cyc, n, ch, ix, spacing, mx;
      aw_delay = v.aw_delay; w_delay = v.w_delay; b_delay = v.b_delay;
      gap_at = v.gap_at; gap_len = v.gap_len; gap_left = v.gap_len; err_at = v.err_at;
      start_in_resp = 0;
      strm_q.delete();
      for (int k = 0; k < WRITES_A + 2; k++) begin
         x = v.fixed ? MA'(16 + k) : MA'($urandom);
         if (k == v.gap_at) x = MA'(12'hABC);
         vals.push_back(x);
         strm_q.push_back(x);
      end
      wlog.delete();
      consumed = 0; done_pulses = 0; done_cyc = -100; last_b_cyc = -100;
      clear_slave();

      start_a = 1'b1;
      tick_a();
      start_a = 1'b0;
      check({v.name, " tready_one_cycle_after_start"}, bus_a.s_axis_tready, 1);
      check({v.name, " busy_after_start"}, busy_a, 1);
      check({v.name, " err_cleared_by_start"}, err_a, 0);

      start_in_resp = v.start_in_resp;
      cyc = 0;
      while (done_pulses == 0 && cyc < 400) begin
         tick_a();
         cyc++;
      end
      start_in_resp = 0;
      start_a = 1'b0;
      check({v.name, " done_within_budget"}, done_pulses, 1);
      check({v.name, " done_after_last_b"}, done_cyc - last_b_cyc, 1);
      repeat (3) tick_a();

      check({v.name, " single_done_pulse"}, done_pulses, 1);
      check({v.name, " busy_low_after"}, busy_a, 0);
      check({v.name, " tready_low_after"}, bus_a.s_axis_tready, 0);
      check({v.name, " err"}, err_a, v.exp_err);
      check({v.name, " values_consumed"}, consumed, v.exp_writes);
      check({v.name, " values_left_in_stream"}, strm_q.size(), WRITES_A + 2 - v.exp_writes);
      check({v.name, " write_count"}, wlog.size(), v.exp_writes);

      n  = (wlog.size() < v.exp_writes) ? wlog.size() : v.exp_writes;
      mx = (v.aw_delay > v.w_delay) ? v.aw_delay : v.w_delay;
      for (int k = 0; k < n; k++) begin
         ch = k / PER_CH_A;
         ix = k % PER_CH_A;
         check($sformatf("%s awaddr[%0d]", v.name, k), wlog[k].addr, ch * (1 << NA) + ix);
         check($sformatf("%s wdata[%0d]", v.name, k), wlog[k].data, 32'(vals[k]));
         check($sformatf("%s wstrb[%0d]", v.name, k), wlog[k].strb, 4'hF);
         check($sformatf("%s awvalid_cycles[%0d]", v.name, k), wlog[k].aw_cyc, v.aw_delay + 1);
         check($sformatf("%s wvalid_cycles[%0d]", v.name, k), wlog[k].w_cyc, v.w_delay + 1);
         if (k > 0) begin
            spacing = 3 + mx + v.b_delay + ((k == v.gap_at) ? v.gap_len : 0);
            check($sformatf("%s write_spacing[%0d]", v.name, k), wlog[k].aw_t - wlog[k-1].aw_t, spacing);
         end
      end
   endtask

   task automatic run_b();
      logic [MB-1:0]      vals[$];
      logic [ABITS_B-1:0] addrs[$];
      logic [31:0]        datas[$];
      int idx, dones, cyc;
      for (int k = 0; k < WRITES_B + 1; k++) vals.push_back(MB'($urandom));
      idx = 0; dones = 0; cyc = 0;
      bus_b.m_axilite_AWREADY = 1'b1;
      bus_b.m_axilite_WREADY  = 1'b1;
      bus_b.m_axilite_BVALID  = 1'b1;
      bus_b.m_axilite_BRESP   = 2'b00;
      start_b = 1'b1;
      while (dones == 0 && cyc < 200) begin
         if (done_b) dones++;
         bus_b.s_axis_tvalid = (idx < vals.size());
         bus_b.s_axis_tdata  = vals[idx];
         if (bus_b.m_axilite_AWVALID) addrs.push_back(bus_b.m_axilite_AWADDR);
         if (bus_b.m_axilite_WVALID)  datas.push_back(bus_b.m_axilite_WDATA);
         if (bus_b.s_axis_tvalid && bus_b.s_axis_tready) idx++;
         @(negedge clk);
         start_b = 1'b0;
         cyc++;
      end
      check("c1 done_seen", dones, 1);
      check("c1 busy_low_after", busy_b, 0);
      check("c1 err", err_b, 0);
      check("c1 aw_count", addrs.size(), WRITES_B);
      check("c1 w_count", datas.size(), WRITES_B);
      check("c1 values_consumed", idx, WRITES_B);
      for (int k = 0; k < WRITES_B && k < addrs.size() && k < datas.size(); k++) begin
         check($sformatf("c1 awaddr[%0d]", k), addrs[k], k);
         check($sformatf("c1 wdata[%0d]", k), datas[k], 32'(vals[k]));
      end
      bus_b.s_axis_tvalid = 1'b0;
      bus_b.m_axilite_BVALID = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{"zero_wait",     0, 0, 0, -1, 0, -1, 1'b0, 1'b1, WRITES_A, 1'b0};
      tbl[1]  = '{"aw_delay3",     3, 0, 0, -1, 0, -1, 1'b0, 1'b0, WRITES_A, 1'b0};
      tbl[2]  = '{"stream_stall5", 0, 0, 0,  2, 5, -1, 1'b0, 1'b0, WRITES_A, 1'b0};
      tbl[3]  = '{"bresp_err",     0, 0, 1, -1, 0,  2, 1'b0, 1'b0, ERR_WRITES, ERR_FLAG};
      tbl[4]  = '{"start_in_resp", 0, 0, 2, -1, 0, -1, 1'b1, 1'b0, WRITES_A, 1'b0};
      tbl[5]  = '{"w_delay2",      1, 2, 3, -1, 0, -1, 1'b0, 1'b0, WRITES_A, 1'b0};
      for (int i = 6; i < 11; i++)
         tbl[i] = '{$sformatf("random%0d", i), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), -1, 0, -1, 1'($urandom_range(0, 1)), 1'b0, WRITES_A, 1'b0};

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; gcyc = 0;
      bus_a.s_axis_tvalid = 0; bus_a.s_axis_tdata = '0;
      bus_a.m_axilite_AWREADY = 0; bus_a.m_axilite_WREADY = 0;
      bus_a.m_axilite_BVALID = 0; bus_a.m_axilite_BRESP = 2'b00;
      bus_b.s_axis_tvalid = 0; bus_b.s_axis_tdata = '0;
      bus_b.m_axilite_AWREADY = 0; bus_b.m_axilite_WREADY = 0;
      bus_b.m_axilite_BVALID = 0; bus_b.m_axilite_BRESP = 2'b00;
      aw_delay = 0; w_delay = 0; b_delay = 0; gap_at = -1; gap_len = 0; gap_left = 0; err_at = -1;
      start_in_resp = 0;
      clear_slave();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("reset busy", busy_a, 0);
      check("reset done", done_a, 0);
      check("reset err", err_a, 0);
      check("reset tready", bus_a.s_axis_tready, 0);
      check("reset awvalid", bus_a.m_axilite_AWVALID, 0);
      check("reset wvalid", bus_a.m_axilite_WVALID, 0);
      check("reset bready", bus_a.m_axilite_BREADY, 0);
      check("reset awaddr", bus_a.m_axilite_AWADDR, 0);
      check("reset wdata", bus_a.m_axilite_WDATA, 0);
      check("reset c1 busy", busy_b, 0);

      for (int i = 0; i < 11; i++) run_seq(tbl[i]);

      // Reset while the address/data phase is pending
      strm_q.delete();
      for (int k = 0; k < 4; k++) strm_q.push_back(MA'($urandom));
      consumed = 0; gap_at = -1; err_at = -1; aw_delay = 50; w_delay = 50; b_delay = 0;
      clear_slave();
      start_a = 1'b1;
      tick_a();
      start_a = 1'b0;
      for (int k = 0; k < 10 && !bus_a.m_axilite_AWVALID; k++) tick_a();
      check("rst_mid issue_reached", bus_a.m_axilite_AWVALID, 1);
      rst = 1'b1;
      tick_a();
      rst = 1'b0;
      check("rst_mid awvalid", bus_a.m_axilite_AWVALID, 0);
      check("rst_mid wvalid", bus_a.m_axilite_WVALID, 0);
      check("rst_mid bready", bus_a.m_axilite_BREADY, 0);
      check("rst_mid tready", bus_a.s_axis_tready, 0);
      check("rst_mid busy", busy_a, 0);
      check("rst_mid done", done_a, 0);
      check("rst_mid awaddr", bus_a.m_axilite_AWADDR, 0);
      check("rst_mid wdata", bus_a.m_axilite_WDATA, 0);
      clear_slave();
      bus_a.m_axilite_AWREADY = 0; bus_a.m_axilite_WREADY = 0;
      run_seq('{"after_rst", 0, 0, 0, -1, 0, -1, 1'b0, 1'b0, WRITES_A, 1'b0});

      run_b();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/thresholding_axilite_writer.md
# thresholding_axilite_writer

AXI-Lite initiator that loads a complete threshold table into a thresholding core's AXI-Lite configuration port. It consumes threshold values from an AXI-Stream and issues one single-beat AXI-Lite write per value, sweeping channels and threshold indices in fixed order. It sits between a weight/threshold stream source (DMA or ROM streamer) and the `s_axilite` write channels of a thresholding block, and replaces host-driven threshold programming.

## Interface
- N, 4: output precision of the target core; each channel holds 2^N-1 thresholds.
- M, 16: threshold precision in bits (M ≤ 32).
- C, 1: channel count.
- A_BITS, $clog2(C)+N (localparam): AXI-Lite address width.
- C_BITS, C<2 ? 1 : $clog2(C) (localparam): channel counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a load sequence; sampled only in IDLE.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the sequence ends.
- err  out  1  sticky write-error flag; cleared by start or rst.
- s_axis_tvalid  in  1  threshold value valid.
- s_axis_tready  out  1  threshold value accepted.
- s_axis_tdata  in  ((M+7)/8)*8  threshold value; bits [M-1:0] used.
- m_axilite_AWVALID / AWREADY  out / in  1 / 1  write address handshake.
- m_axilite_AWADDR  out  A_BITS  {channel, index}.
- m_axilite_WVALID / WREADY  out / in  1 / 1  write data handshake.
- m_axilite_WDATA  out  32  threshold, zero-extended from M bits.
- m_axilite_WSTRB  out  4  constant 4'hF.
- m_axilite_BVALID / BREADY  in / out  1 / 1  write response handshake.
- m_axilite_BRESP  in  2  write response code.

## Operation
- States: IDLE, FETCH, ISSUE, RESP, DONE.
- IDLE: all valids/readies low. start=1 → FETCH; clears err, index and channel counters.
- FETCH: s_axis_tready=1. On tvalid: latch tdata[M-1:0] → ISSUE.
- ISSUE: AWVALID and WVALID raised together on state entry. Each drops independently on its own handshake (VALID&&READY). AWADDR/WDATA held stable until that channel completes. When both are complete (including both in the same cycle) → RESP.
- RESP: BREADY=1. On BVALID: if index = 2^N-2, index←0 and channel++; else index++. Response for last index of channel C-1 → DONE; otherwise → FETCH.
- DONE: done=1 for one cycle → IDLE.
- Address: AWADDR = (channel << N) | index; for C=1, AWADDR = index. Index 2^N-1 is never written.
- Total writes per sequence: C·(2^N-1). Stream must supply exactly that many values; extra values stay in the stream and are not consumed.
- start while busy: ignored.
- One outstanding transaction at most; no AR/R channels.

## Timing
- Reset values: busy=0, done=0, err=0, s_axis_tready=0, AWVALID=0, WVALID=0, BREADY=0, AWADDR=0, WDATA=0.
- rst mid-sequence: next cycle IDLE, all outputs at reset values, counters cleared; a pending transaction is abandoned (the target shares rst).
- start→first s_axis_tready: 1 cycle.
- Minimum 3 cycles per write (FETCH, ISSUE, RESP) with zero-wait target; BVALID may arrive in the first RESP cycle.
- done asserts the cycle after the final B handshake; busy falls in the same cycle as done's fall (busy high during DONE).
- No combinational path from any input to any VALID/READY output; all handshake outputs are registered state decodes.

## Configuration
- THRESHOLDING_WRITER_BRESP_CHECK_EN defined: BRESP≠2'b00 on a B handshake sets err and terminates the sequence (RESP → DONE); no further stream values consumed.
- Not defined: BRESP ignored, err tied to 0, sequence always completes all writes.

## Test plan
- N=2, M=8, C=2, zero-wait slave, stream 0x10..0x15 → six writes, AWADDR 0,1,2,4,5,6 with WDATA 0x10..0x15, WSTRB=F; one done pulse; busy low afterwards.
- AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held 4 cycles with stable AWADDR; BREADY rises only after both; data correct.
- s_axis_tvalid low for 5 cycles during FETCH, then M=12 value 0xABC → AWVALID stays low during stall; WDATA=0x00000ABC.
- Macro defined, BRESP=2'b10 on third write (N=2, C=2) → err=1, done pulse, only 3 stream values consumed; next start clears err. Macro undefined → all 6 writes complete, err=0.
- rst asserted while AWVALID high in ISSUE → next cycle all valids 0, busy 0; fresh start reloads from AWADDR 0.
- start pulsed during RESP → ignored; write count stays C·(2^N-1); C=1, N=3 → AWADDR 0..6.
